// File: rtl/conv_window_fetch.sv
// Raster-scan SRAM reader that builds 3x3 pixel windows through two line buffers and a skid register.
// Optional feature: define CONV_WIN_FRAME_CNT_EN to add the frame_cnt output.
module conv_window_fetch #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_d,
    input  logic [7:0]        sram_q,
    output logic [71:0]       win,
    output logic [ADDR_W-1:0] win_x,
    output logic [ADDR_W-1:0] win_y,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              busy,
`ifdef CONV_WIN_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic              done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = $clog2(IMG_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic              q_valid;
    logic              skid_full;
    logic [7:0]        skid_data;
    logic [XW-1:0]     px;
    logic [ADDR_W-1:0] py;
    logic [7:0]        lb0 [IMG_W];
    logic [7:0]        lb1 [IMG_W];
    logic [23:0]       col0, col1, col_new;
    logic [71:0]       win_nxt;
    logic [7:0]        pix;
    logic              stall, issue, last_read, pix_take, make_win, last_win_acc;

    assign stall        = win_valid && !win_ready;
    assign issue        = (state == RUN) && !stall && !skid_full;
    assign last_read    = issue && (rd_addr == ADDR_W'(NPIX - 1));
    assign pix_take     = (q_valid || skid_full) && !stall;
    assign pix          = skid_full ? skid_data : sram_q;
    assign make_win     = pix_take && (px >= XW'(2)) && (py >= ADDR_W'(2));
    assign last_win_acc = win_valid && win_ready &&
                          (win_x == ADDR_W'(IMG_W - 2)) && (win_y == ADDR_W'(IMG_H - 2));

    // Column layout is {top, middle, bottom}; win packs k = row*3 + col from the LSB up.
    assign col_new = {lb1[px], lb0[px], pix};
    assign win_nxt = {col_new[7:0],   col1[7:0],   col0[7:0],
                      col_new[15:8],  col1[15:8],  col0[15:8],
                      col_new[23:16], col1[23:16], col0[23:16]};

    assign sram_en   = issue;
    assign sram_wen  = 1'b1;
    assign sram_d    = 8'd0;
    assign sram_addr = rd_addr;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_read) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_win_acc) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= '0;
            q_valid   <= 1'b0;
            skid_full <= 1'b0;
            skid_data <= 8'd0;
            px        <= '0;
            py        <= '0;
            col0      <= '0;
            col1      <= '0;
            win       <= '0;
            win_x     <= '0;
            win_y     <= '0;
            win_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            q_valid <= issue;
            if (issue && !last_read) rd_addr <= rd_addr + 1'b1;

            // Read data landing during a stall is parked; reads pause until it drains.
            if (q_valid && stall) begin
                skid_full <= 1'b1;
                skid_data <= sram_q;
            end else if (skid_full && !stall) begin
                skid_full <= 1'b0;
            end

            if (pix_take) begin
                col0 <= col1;
                col1 <= col_new;
                if (px == XW'(IMG_W - 1)) begin
                    px <= '0;
                    py <= py + 1'b1;
                end else begin
                    px <= px + 1'b1;
                end
            end

            if (make_win) begin
                win       <= win_nxt;
                win_x     <= ADDR_W'(px) - ADDR_W'(1);
                win_y     <= py - ADDR_W'(1);
                win_valid <= 1'b1;
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end

            if (state == IDLE) begin
                rd_addr <= '0;
                px      <= '0;
                py      <= '0;
            end
        end
    end

    // Line buffer contents need no reset: rows 0 and 1 never reach a window.
    always_ff @(posedge clk) begin
        if (pix_take) begin
            lb1[px] <= lb0[px];
            lb0[px] <= pix;
        end
    end

`ifdef CONV_WIN_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) frame_cnt <= 16'd0;
        else if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule
